rd_mst_arbiter: RTL and testbench

//  Shares one AXI read master between the conv_engine IFM and WGT switch_buffers.

---
 rtl/rd_mst_arbiter_pkg.sv | 26 ++
 rtl/rd_mst_arbiter_if.sv | 54 +++++
 rtl/rd_mst_arbiter_rr_arb2.sv | 36 +++
 rtl/rd_mst_arbiter.sv | 160 ++++++++++++++++
 tb/tb_rd_mst_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rd_mst_arbiter_pkg.sv
// Shared types for the conv_engine read-master arbiter: FSM encoding, requester IDs
// and transfer-size defaults.
package rd_mst_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_XFER  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_e;

  typedef enum logic {
    REQ_IFM = 1'b0,
    REQ_WGT = 1'b1
  } req_id_e;

  localparam int DATA_WIDTH_DEFAULT = 512;
  localparam int ADDR_WIDTH_DEFAULT = 64;
  localparam int XFER_BYTES_DEFAULT = 4096;

  // Stream beats needed to move one transfer of xfer_bytes.
  function automatic int calc_beats(input int xfer_bytes, input int data_width);
    return xfer_bytes / (data_width / 8);
  endfunction

endpackage

// File: rtl/rd_mst_arbiter_if.sv
// Bundle of the two switch_buffer channels plus the shared read-master command and stream.
// The master modport is the arbiter's view; slave is the surrounding buffers/read master.
interface rd_mst_arbiter_if
  import rd_mst_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT
);

  logic                  ifm_req;
  logic [ADDR_WIDTH-1:0] ifm_addr_base;
  logic [ADDR_WIDTH-1:0] ifm_offset;
  logic                  ifm_done;
  logic                  ifm_tvalid;
  logic [DATA_WIDTH-1:0] ifm_tdata;
  logic                  ifm_tready;

  logic                  wgt_req;
  logic [ADDR_WIDTH-1:0] wgt_addr_base;
  logic [ADDR_WIDTH-1:0] wgt_offset;
  logic                  wgt_done;
  logic                  wgt_tvalid;
  logic [DATA_WIDTH-1:0] wgt_tdata;
  logic                  wgt_tready;

  logic                  rmst_req;
  logic [ADDR_WIDTH-1:0] rmst_addr;
  logic [ADDR_WIDTH-1:0] rmst_size;
  logic                  rmst_done;
  logic                  axis_rmst_tvalid;
  logic [DATA_WIDTH-1:0] axis_rmst_tdata;
  logic                  axis_rmst_tready;

  modport master (
    input  ifm_req, ifm_addr_base, ifm_offset, ifm_tready,
    output ifm_done, ifm_tvalid, ifm_tdata,
    input  wgt_req, wgt_addr_base, wgt_offset, wgt_tready,
    output wgt_done, wgt_tvalid, wgt_tdata,
    output rmst_req, rmst_addr, rmst_size,
    input  rmst_done, axis_rmst_tvalid, axis_rmst_tdata,
    output axis_rmst_tready
  );

  modport slave (
    output ifm_req, ifm_addr_base, ifm_offset, ifm_tready,
    input  ifm_done, ifm_tvalid, ifm_tdata,
    output wgt_req, wgt_addr_base, wgt_offset, wgt_tready,
    input  wgt_done, wgt_tvalid, wgt_tdata,
    input  rmst_req, rmst_addr, rmst_size,
    output rmst_done, axis_rmst_tvalid, axis_rmst_tdata,
    input  axis_rmst_tready
  );

endinterface

// File: rtl/rd_mst_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, registered record of the last winner.
module rd_mst_arbiter_rr_arb2
  import rd_mst_arbiter_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    req_ifm,
  input  logic    req_wgt,
  input  logic    update,
  input  req_id_e update_id,
  output logic    grant_valid,
  output req_id_e grant_id
);

  req_id_e last_grant_q;

  // Starting from WGT makes the first tie after reset go to IFM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= REQ_WGT;
    end else if (update) begin
      last_grant_q <= update_id;
    end
  end

  always_comb begin
    grant_valid = req_ifm | req_wgt;
    grant_id    = REQ_IFM;
    if (req_ifm && req_wgt) begin
      grant_id = (last_grant_q == REQ_IFM) ? REQ_WGT : REQ_IFM;
    end else if (req_wgt) begin
      grant_id = REQ_WGT;
    end
  end

endmodule

// File: rtl/rd_mst_arbiter.sv
// Shares one AXI read master between the IFM and WGT switch_buffers: round-robin grant,
// single transfer issue, zero-latency stream steering and per-transfer done pulse.
module rd_mst_arbiter
  import rd_mst_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT,
  parameter int XFER_BYTES = XFER_BYTES_DEFAULT
)(
  input  logic              clk,
  input  logic              rst_n,
  rd_mst_arbiter_if.master  bus,
  output logic              busy,
  output logic              err
);

  localparam int BEATS = calc_beats(XFER_BYTES, DATA_WIDTH);
  localparam int CNT_W = $clog2(BEATS + 1);
  localparam logic [CNT_W-1:0] BEATS_C = CNT_W'(BEATS);
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(BEATS - 1);

  arb_state_e            state_q, state_d;
  req_id_e               grant_q, grant_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
  logic                  done_seen_q, done_seen_d;
  logic                  err_q, err_d;

  logic                  arb_valid;
  req_id_e               arb_id;
  logic                  arb_update;
  logic                  granted_tready;
  logic                  beat_room;
  logic                  beat_fire;
  logic                  all_beats;
  logic                  rd_done;

  rd_mst_arbiter_rr_arb2 u_rr_arb2 (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_ifm     (bus.ifm_req),
    .req_wgt     (bus.wgt_req),
    .update      (arb_update),
    .update_id   (grant_q),
    .grant_valid (arb_valid),
    .grant_id    (arb_id)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      grant_q     <= REQ_IFM;
      addr_q      <= '0;
      beat_cnt_q  <= '0;
      done_seen_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      addr_q      <= addr_d;
      beat_cnt_q  <= beat_cnt_d;
      done_seen_q <= done_seen_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d              = state_q;
    grant_d              = grant_q;
    addr_d               = addr_q;
    beat_cnt_d           = beat_cnt_q;
    done_seen_d          = done_seen_q;
    err_d                = err_q;
    arb_update           = 1'b0;
    beat_fire            = 1'b0;
    all_beats            = 1'b0;
    rd_done              = 1'b0;
    bus.rmst_req         = 1'b0;
    bus.rmst_addr        = '0;
    bus.axis_rmst_tready = 1'b0;
    bus.ifm_tvalid       = 1'b0;
    bus.wgt_tvalid       = 1'b0;
    bus.ifm_done         = 1'b0;
    bus.wgt_done         = 1'b0;

    granted_tready = (grant_q == REQ_WGT) ? bus.wgt_tready : bus.ifm_tready;
    beat_room      = (beat_cnt_q != BEATS_C);

    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          grant_d     = arb_id;
          addr_d      = (arb_id == REQ_WGT) ? (bus.wgt_addr_base + bus.wgt_offset)
                                            : (bus.ifm_addr_base + bus.ifm_offset);
          beat_cnt_d  = '0;
          done_seen_d = 1'b0;
          state_d     = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        bus.rmst_req  = 1'b1;
        bus.rmst_addr = addr_q;
        state_d       = ST_XFER;
      end

      ST_XFER: begin
        // Once the full transfer is in, the buffer must not see surplus beats either.
        if (beat_room) begin
          bus.axis_rmst_tready = granted_tready;
          if (grant_q == REQ_WGT) begin
            bus.wgt_tvalid = bus.axis_rmst_tvalid;
          end else begin
            bus.ifm_tvalid = bus.axis_rmst_tvalid;
          end
        end else if (bus.axis_rmst_tvalid) begin
          err_d = 1'b1;
        end
        beat_fire = beat_room && bus.axis_rmst_tvalid && granted_tready;
        if (beat_fire) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end
        if (bus.rmst_done) begin
          done_seen_d = 1'b1;
        end
        all_beats = !beat_room || (beat_fire && (beat_cnt_q == LAST_C));
        rd_done   = done_seen_q || bus.rmst_done;
        if (all_beats && rd_done) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        if (grant_q == REQ_WGT) begin
          bus.wgt_done = 1'b1;
        end else begin
          bus.ifm_done = 1'b1;
        end
        arb_update = 1'b1;
        state_d    = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A completion with no transfer in flight is a protocol error, otherwise ignored.
    if (bus.rmst_done && (state_q != ST_XFER)) begin
      err_d = 1'b1;
    end
  end

  assign bus.ifm_tdata = bus.axis_rmst_tdata;
  assign bus.wgt_tdata = bus.axis_rmst_tdata;
  assign bus.rmst_size = ADDR_WIDTH'(XFER_BYTES);
  assign busy          = (state_q != ST_IDLE);
  assign err           = err_q;

endmodule

// File: tb/tb_rd_mst_arbiter.sv
// Scoreboard bench for rd_mst_arbiter: beats accepted from the read master are queued per
// expected owner and matched against what the granted buffer receives.
module tb_rd_mst_arbiter;

  localparam int DW    = 512;
  localparam int AW    = 64;
  localparam int XB    = 4096;
  localparam int BEATS = XB / (DW / 8);

  logic clk = 1'b0;
  logic rst_n;
  logic busy;
  logic err;

  rd_mst_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  rd_mst_arbiter #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .XFER_BYTES (XB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy),
    .err   (err)
  );

  always #5 clk = ~clk;

  int errCount   = 0;
  int checkCount = 0;
  logic [DW-1:0] ifmQ[$];
  logic [DW-1:0] wgtQ[$];
  bit curOwner   = 1'b0;
  bit wrongValid = 1'b0;
  int ifmRx      = 0;
  int wgtRx      = 0;
  int ifmDones   = 0;
  int wgtDones   = 0;

  task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected data is queued when the read master hands a beat over, and consumed when the
  // buffer side accepts a beat.
  always @(negedge clk) begin : monitor
    logic [DW-1:0] expData;
    if (rst_n === 1'b1) begin
      if (bus.axis_rmst_tvalid && bus.axis_rmst_tready) begin
        if (curOwner) wgtQ.push_back(bus.axis_rmst_tdata);
        else          ifmQ.push_back(bus.axis_rmst_tdata);
      end
      if (bus.ifm_tvalid && bus.ifm_tready) begin
        ifmRx++;
        checkOutput("ifm_beat_expected", DW'(ifmQ.size() != 0), DW'(1));
        if (ifmQ.size() != 0) begin
          expData = ifmQ.pop_front();
          checkOutput("ifm_tdata", bus.ifm_tdata, expData);
        end
      end
      if (bus.wgt_tvalid && bus.wgt_tready) begin
        wgtRx++;
        checkOutput("wgt_beat_expected", DW'(wgtQ.size() != 0), DW'(1));
        if (wgtQ.size() != 0) begin
          expData = wgtQ.pop_front();
          checkOutput("wgt_tdata", bus.wgt_tdata, expData);
        end
      end
      if (!curOwner && bus.wgt_tvalid) wrongValid = 1'b1;
      if (curOwner && bus.ifm_tvalid)  wrongValid = 1'b1;
      if (bus.ifm_done) ifmDones++;
      if (bus.wgt_done) wgtDones++;
    end
  end

  task automatic driveIdle();
    bus.ifm_req          = 1'b0;
    bus.ifm_addr_base    = '0;
    bus.ifm_offset       = '0;
    bus.ifm_tready       = 1'b1;
    bus.wgt_req          = 1'b0;
    bus.wgt_addr_base    = '0;
    bus.wgt_offset       = '0;
    bus.wgt_tready       = 1'b1;
    bus.rmst_done        = 1'b0;
    bus.axis_rmst_tvalid = 1'b0;
    bus.axis_rmst_tdata  = '0;
  endtask

  task automatic applyStimulus(input bit ifmReq, input logic [AW-1:0] ifmBase, input logic [AW-1:0] ifmOff,
                               input bit wgtReq, input logic [AW-1:0] wgtBase, input logic [AW-1:0] wgtOff);
    @(posedge clk); #1;
    bus.ifm_req       = ifmReq;
    bus.ifm_addr_base = ifmBase;
    bus.ifm_offset    = ifmOff;
    bus.wgt_req       = wgtReq;
    bus.wgt_addr_base = wgtBase;
    bus.wgt_offset    = wgtOff;
  endtask

  task automatic setOwnerTready(input bit owner, input logic v);
    if (owner) bus.wgt_tready = v;
    else       bus.ifm_tready = v;
  endtask

  task automatic waitRmstReq(input logic [AW-1:0] expAddr, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (bus.rmst_req) ok = 1'b1;
    end
    checkOutput("rmst_req_seen", DW'(ok), DW'(1));
    if (ok) begin
      checkOutput("rmst_addr", DW'(bus.rmst_addr), DW'(expAddr));
      checkOutput("rmst_size", DW'(bus.rmst_size), DW'(XB));
      checkOutput("busy_issue", DW'(busy), DW'(1));
      @(negedge clk);
      checkOutput("rmst_req_pulse", DW'(bus.rmst_req), '0);
    end
  endtask

  task automatic sendBeat(input bit owner, input bit stall, output bit ok);
    logic [DW-1:0] d;
    int w;
    for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom;
    @(posedge clk); #1;
    bus.axis_rmst_tvalid = 1'b1;
    bus.axis_rmst_tdata  = d;
    if (stall) begin
      setOwnerTready(owner, 1'b0);
      repeat (10) begin
        @(negedge clk);
        checkOutput("stall_tready", DW'(bus.axis_rmst_tready), '0);
      end
      @(posedge clk); #1;
      setOwnerTready(owner, 1'b1);
    end
    ok = 1'b0;
    w  = 0;
    while (!ok && w < 50) begin
      @(negedge clk);
      if (bus.axis_rmst_tready) ok = 1'b1;
      else begin
        @(posedge clk); #1;
      end
      w++;
    end
    checkOutput("beat_handshake", DW'(ok), DW'(1));
  endtask

  task automatic serveTransfer(input bit owner, input logic [AW-1:0] expAddr, input int stallAt,
                               input bit earlyDone, input bit extraBeat);
    bit ok;
    bit seen;
    int doneBefore;
    int otherBefore;
    waitRmstReq(expAddr, ok);
    if (!ok) return;
    curOwner    = owner;
    wrongValid  = 1'b0;
    ifmRx       = 0;
    wgtRx       = 0;
    doneBefore  = owner ? wgtDones : ifmDones;
    otherBefore = owner ? ifmDones : wgtDones;
    for (int b = 0; b < BEATS; b++) begin
      if (earlyDone && b == BEATS - 4) begin
        @(posedge clk); #1;
        bus.axis_rmst_tvalid = 1'b0;
        bus.rmst_done        = 1'b1;
        @(posedge clk); #1;
        bus.rmst_done = 1'b0;
        @(negedge clk);
        checkOutput("early_no_done", DW'(owner ? bus.wgt_done : bus.ifm_done), '0);
        checkOutput("early_busy", DW'(busy), DW'(1));
      end
      sendBeat(owner, b == stallAt, ok);
      if (!ok) begin
        bus.axis_rmst_tvalid = 1'b0;
        return;
      end
    end
    @(posedge clk); #1;
    bus.axis_rmst_tvalid = 1'b0;
    if (extraBeat) begin
      bus.axis_rmst_tvalid = 1'b1;
      @(negedge clk);
      checkOutput("extra_tready", DW'(bus.axis_rmst_tready), '0);
      @(posedge clk); #1;
      bus.axis_rmst_tvalid = 1'b0;
      @(negedge clk);
      checkOutput("extra_err", DW'(err), DW'(1));
    end
    if (!earlyDone) begin
      @(posedge clk); #1;
      bus.rmst_done = 1'b1;
      @(posedge clk); #1;
      bus.rmst_done = 1'b0;
    end
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (owner ? bus.wgt_done : bus.ifm_done) seen = 1'b1;
    end
    checkOutput("done_seen", DW'(seen), DW'(1));
    if (seen) begin
      checkOutput("done_other_low", DW'(owner ? bus.ifm_done : bus.wgt_done), '0);
      checkOutput("beats_delivered", DW'(owner ? wgtRx : ifmRx), DW'(BEATS));
    end
    @(posedge clk); #1;
    if (owner) bus.wgt_req = 1'b0;
    else       bus.ifm_req = 1'b0;
    @(negedge clk);
    checkOutput("done_pulse_width", DW'(owner ? bus.wgt_done : bus.ifm_done), '0);
    checkOutput("done_count", DW'((owner ? wgtDones : ifmDones) - doneBefore), DW'(1));
    checkOutput("other_done_count", DW'((owner ? ifmDones : wgtDones) - otherBefore), '0);
    checkOutput("no_stray_tvalid", DW'(wrongValid), '0);
    checkOutput("queue_drained", DW'(owner ? wgtQ.size() : ifmQ.size()), '0);
  endtask

  initial begin
    bit ok;
    rst_n = 1'b0;
    driveIdle();
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", DW'(busy), '0);
    checkOutput("rst_err", DW'(err), '0);
    checkOutput("rst_rmst_req", DW'(bus.rmst_req), '0);
    checkOutput("rst_rmst_addr", DW'(bus.rmst_addr), '0);
    checkOutput("rst_rmst_size", DW'(bus.rmst_size), DW'(XB));
    checkOutput("rst_axis_tready", DW'(bus.axis_rmst_tready), '0);
    checkOutput("rst_ifm_done", DW'(bus.ifm_done), '0);
    checkOutput("rst_wgt_tvalid", DW'(bus.wgt_tvalid), '0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // First tie after reset goes to IFM; base+offset wraps at 64 bits.
    applyStimulus(1'b1, 64'hFFFF_FFFF_FFFF_FF00, 64'h200, 1'b1, 64'h0008_0000, 64'h80);
    serveTransfer(1'b0, 64'h100, -1, 1'b0, 1'b0);
    serveTransfer(1'b1, 64'h0008_0080, -1, 1'b0, 1'b0);

    // WGT won last, so the next tie returns to IFM.
    applyStimulus(1'b1, 64'h3000, 64'h0, 1'b1, 64'h4000, 64'h10);
    serveTransfer(1'b0, 64'h3000, -1, 1'b0, 1'b0);
    serveTransfer(1'b1, 64'h4010, -1, 1'b0, 1'b0);

    applyStimulus(1'b1, 64'h1000, 64'h40, 1'b0, 64'h0, 64'h0);
    serveTransfer(1'b0, 64'h1040, -1, 1'b0, 1'b0);

    applyStimulus(1'b1, 64'h5000, 64'h100, 1'b0, 64'h0, 64'h0);
    serveTransfer(1'b0, 64'h5100, 20, 1'b0, 1'b0);

    applyStimulus(1'b0, 64'h0, 64'h0, 1'b1, 64'h6000, 64'h0);
    serveTransfer(1'b1, 64'h6000, -1, 1'b1, 1'b0);
    checkOutput("err_still_clear", DW'(err), '0);

    applyStimulus(1'b1, 64'h7000, 64'h0, 1'b0, 64'h0, 64'h0);
    serveTransfer(1'b0, 64'h7000, -1, 1'b0, 1'b1);

    // Reset in the middle of a transfer, with the request still held.
    applyStimulus(1'b1, 64'h2000, 64'h20, 1'b0, 64'h0, 64'h0);
    waitRmstReq(64'h2020, ok);
    curOwner = 1'b0;
    for (int b = 0; b < 10 && ok; b++) sendBeat(1'b0, 1'b0, ok);
    @(posedge clk); #1;
    bus.axis_rmst_tvalid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy", DW'(busy), '0);
    checkOutput("midrst_err", DW'(err), '0);
    checkOutput("midrst_axis_tready", DW'(bus.axis_rmst_tready), '0);
    checkOutput("midrst_ifm_tvalid", DW'(bus.ifm_tvalid), '0);
    checkOutput("midrst_rmst_req", DW'(bus.rmst_req), '0);
    ifmQ.delete();
    wgtQ.delete();
    repeat (3) begin
      @(negedge clk);
      checkOutput("midrst_no_done", DW'(bus.ifm_done), '0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    serveTransfer(1'b0, 64'h2020, -1, 1'b0, 1'b0);

    // Completion pulse with nothing in flight.
    @(posedge clk); #1;
    bus.rmst_done = 1'b1;
    @(posedge clk); #1;
    bus.rmst_done = 1'b0;
    @(negedge clk);
    checkOutput("idle_done_err", DW'(err), DW'(1));
    checkOutput("idle_done_busy", DW'(busy), '0);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
